dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the processor's byte-addressed data memory (1024 cells, 12-bit address, synchronous write, combinational read with size/sign selection). Shares the single memory port between the core load/store unit (port 0) and the program/data loader (port 1). Requests are registered, issued to memory for exactly one cycle, and answered through a response handshake. Also provides fairness, a loader burst lock with starvation protection, and out-of-range address rejection.

---
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port arbiter/sequencer for the byte-addressed data memory
//            with round-robin fairness, loader lock and range rejection.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int MAX_WAIT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic [11:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_we,
    input  logic [2:0]  p0_size,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p0_rready,
    input  logic        p1_req,
    input  logic [11:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_we,
    input  logic [2:0]  p1_size,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    input  logic        p1_rready,
    input  logic        p1_lock,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_we,
    output logic [2:0]  mem_read_size,
    input  logic [31:0] mem_rd_data
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_access = 2'd1;
    localparam logic [1:0] c_resp   = 2'd2;

    localparam int                  c_wait_w   = $clog2(MAX_WAIT + 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MAX_WAIT);
    localparam logic [12:0]         c_mem_end  = 13'(MEM_BYTES);

    logic [1:0]          r_state;
    logic [11:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_we;
    logic [2:0]          r_size;
    logic                r_owner;
    logic                r_err;
    logic [31:0]         r_rdata;
    logic                r_last_gnt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic                r_locked;

    logic                w_idle;
    logic                w_pick1;
    logic                w_grant;
    logic                w_lock_win;
    logic [11:0]         w_addr;
    logic [2:0]          w_size;
    logic [2:0]          w_nbytes;
    logic                w_err;
    logic                w_resp;
    logic                w_hs;
    logic [c_wait_w-1:0] w_wait_inc;

    assign w_idle     = (r_state == c_idle);
    assign w_lock_win = r_locked & p1_lock & (r_wait_cnt < c_wait_max);
    // On a tie the lock wins only while port 0 has not waited too long.
    assign w_pick1    = (p0_req & p1_req) ? (w_lock_win | ~r_last_gnt) : p1_req;
    assign w_grant    = rst_n & w_idle & (p0_req | p1_req);
    assign p0_gnt     = w_grant & ~w_pick1;
    assign p1_gnt     = w_grant & w_pick1;

    assign w_addr = w_pick1 ? p1_addr : p0_addr;
    assign w_size = w_pick1 ? p1_size : p0_size;

    always_comb begin
        w_nbytes = 3'd4;
        case (w_size[1:0])
            2'b00:   w_nbytes = 3'd1;
            2'b01:   w_nbytes = 3'd2;
            default: w_nbytes = 3'd4;
        endcase
    end

    assign w_err      = ({1'b0, w_addr} + {10'b0, w_nbytes}) > c_mem_end;
    assign w_wait_inc = (r_wait_cnt == c_wait_max) ? r_wait_cnt : r_wait_cnt + 1'b1;

    assign w_resp    = rst_n & (r_state == c_resp);
    assign p0_rvalid = w_resp & ~r_owner;
    assign p1_rvalid = w_resp & r_owner;
    assign p0_rdata  = p0_rvalid ? r_rdata : 32'h0;
    assign p1_rdata  = p1_rvalid ? r_rdata : 32'h0;
    assign p0_err    = p0_rvalid & r_err;
    assign p1_err    = p1_rvalid & r_err;
    assign w_hs      = r_owner ? (p1_rvalid & p1_rready) : (p0_rvalid & p0_rready);

    // rst_n gates the strobe so a reset during ACCESS never commits the write.
    assign mem_addr      = r_addr;
    assign mem_wr_data   = r_wdata;
    assign mem_read_size = r_size;
    assign mem_we        = rst_n & (r_state == c_access) & r_we & ~r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_addr     <= 12'h0;
            r_wdata    <= 32'h0;
            r_we       <= 1'b0;
            r_size     <= 3'h0;
            r_owner    <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= 32'h0;
            r_last_gnt <= 1'b1;
            r_wait_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_grant) begin
                        r_addr     <= w_addr;
                        r_wdata    <= w_pick1 ? p1_wdata : p0_wdata;
                        r_we       <= w_pick1 ? p1_we : p0_we;
                        r_size     <= w_size;
                        r_owner    <= w_pick1;
                        r_last_gnt <= w_pick1;
                        r_err      <= w_err;
                        r_state    <= c_access;
                    end
                    if (w_grant & w_pick1 & p1_lock) begin
                        r_locked <= 1'b1;
                    end else if ((w_grant & ~w_pick1) | ~p1_lock) begin
                        r_locked <= 1'b0;
                    end
                    if (w_grant & ~w_pick1) begin
                        r_wait_cnt <= '0;
                    end else if (w_grant & p0_req) begin
                        r_wait_cnt <= w_wait_inc;
                    end
                end
                c_access: begin
                    r_rdata <= (r_we | r_err) ? 32'h0 : mem_rd_data;
                    r_state <= c_resp;
                    if (p0_req) r_wait_cnt <= w_wait_inc;
                end
                c_resp: begin
                    if (w_hs) r_state <= c_idle;
                    if (p0_req) r_wait_cnt <= w_wait_inc;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed scoreboard bench for dmem_arbiter with a byte memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err, p0_rready;
    logic [11:0] p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic [2:0]  p0_size;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err, p1_rready, p1_lock;
    logic [11:0] p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic [2:0]  p1_size;
    logic [11:0] mem_addr;
    logic [31:0] mem_wr_data, mem_rd_data;
    logic        mem_we;
    logic [2:0]  mem_read_size;

    dmem_arbiter #(.MEM_BYTES(1024), .MAX_WAIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
        .p0_size(p0_size), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p0_err(p0_err), .p0_rready(p0_rready),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
        .p1_size(p1_size), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p1_err(p1_err), .p1_rready(p1_rready), .p1_lock(p1_lock),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_we(mem_we),
        .mem_read_size(mem_read_size), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Byte memory: synchronous little-endian write, combinational sized read.
    logic [7:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if ((i == 0 || (i == 1 && mem_read_size[1:0] != 2'b00) || mem_read_size[1]) &&
                    (int'(mem_addr) + i < 1024))
                    mem[int'(mem_addr) + i] <= mem_wr_data[8*i +: 8];
            end
        end
    end

    logic [7:0] rb [4];
    always_comb begin
        for (int i = 0; i < 4; i++)
            rb[i] = (int'(mem_addr) + i < 1024) ? mem[int'(mem_addr) + i] : 8'h00;
        case (mem_read_size[1:0])
            2'b00:   mem_rd_data = mem_read_size[2] ? {24'h0, rb[0]} : {{24{rb[0][7]}}, rb[0]};
            2'b01:   mem_rd_data = mem_read_size[2] ? {16'h0, rb[1], rb[0]}
                                                    : {{16{rb[1][7]}}, rb[1], rb[0]};
            default: mem_rd_data = {rb[3], rb[2], rb[1], rb[0]};
        endcase
    end

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       sb [$];
    int          glog [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          we_cnt = 0;
    logic [31:0] exp_rdata [2];
    logic        exp_err [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input bit port, input logic [31:0] rdata, input logic err);
        resp_t e;
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL sb_underflow observed=response_port%0d expected=none", port);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_port", {31'b0, port}, {31'b0, e.port});
            chk("resp_rdata", rdata, e.rdata);
            chk("resp_err", {31'b0, err}, {31'b0, e.err});
        end
    endtask

    task automatic next();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called once per cycle right after the inputs are driven.
    task automatic sample();
        #1;
        if (p0_gnt) begin sb.push_back('{1'b0, exp_rdata[0], exp_err[0]}); glog.push_back(0); end
        if (p1_gnt) begin sb.push_back('{1'b1, exp_rdata[1], exp_err[1]}); glog.push_back(1); end
        chk("single_rvalid", {31'b0, p0_rvalid & p1_rvalid}, 32'h0);
        if (mem_we) we_cnt++;
        if (p0_rvalid && p0_rready) sb_pop(1'b0, p0_rdata, p0_err);
        if (p1_rvalid && p1_rready) sb_pop(1'b1, p1_rdata, p1_err);
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input logic [11:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_size = size; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_size = size; p0_wdata = wdata;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ctl"}, {25'b0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we}, 32'h0);
        chk({tag, "_rdata"}, p0_rdata | p1_rdata, 32'h0);
        chk({tag, "_mem"}, {8'b0, mem_addr, mem_read_size, 9'b0} | mem_wr_data, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;
        next(); next();
        rst_n = 1'b1;
        sb.delete();
        glog.delete();
    endtask

    task automatic txn(input bit port, input bit we, input logic [11:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [31:0] erd, input bit eerr,
                       input int ewe, input string tag);
        int g = -1;
        int r = -1;
        exp_rdata[port] = erd;
        exp_err[port]   = eerr;
        we_cnt = 0;
        p0_rready = 1'b1; p1_rready = 1'b1;
        drive(port, 1'b1, we, addr, size, wdata);
        for (int c = 0; c < 30 && r < 0; c++) begin
            sample();
            if (g < 0 && (port ? p1_gnt : p0_gnt)) g = c;
            if (port ? p1_rvalid : p0_rvalid) r = c;
            next();
            if (g >= 0) drive(port, 1'b0, we, addr, size, wdata);
        end
        chk({tag, "_done"}, {31'b0, r >= 0}, 32'h1);
        chk({tag, "_latency"}, r - g, 32'd2);
        chk({tag, "_we_cycles"}, we_cnt, ewe);
    endtask

    task automatic run_both(input int n, input bit lock, input string tag);
        bit done = 1'b0;
        glog.delete();
        exp_rdata[0] = 32'h0; exp_err[0] = 1'b0;
        exp_rdata[1] = 32'h0; exp_err[1] = 1'b0;
        p0_rready = 1'b1; p1_rready = 1'b1; p1_lock = lock;
        drive(1'b0, 1'b1, 1'b1, 12'h100, SZ_W, 32'hA0A0_0000);
        drive(1'b1, 1'b1, 1'b1, 12'h200, SZ_W, 32'hB1B1_0000);
        for (int c = 0; c < 200 && !done; c++) begin
            sample();
            next();
            if (glog.size() >= n) begin p0_req = 1'b0; p1_req = 1'b0; end
            done = (glog.size() >= n) && (sb.size() == 0);
        end
        chk({tag, "_done"}, {31'b0, done}, 32'h1);
        p1_lock = 1'b0;
    endtask

    int rr_exp [4]   = '{0, 1, 0, 1};
    // Tie goes to 0 first; the lock then holds port 1 until port 0 has waited
    // 8 cycles (3 per port-1 transaction, counting port 0's own busy cycles).
    int lock_exp [7] = '{0, 1, 1, 0, 1, 1, 0};

    initial begin
        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_size = 0; p0_rready = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_size = 0; p1_rready = 0;
        p1_lock = 0;
        exp_rdata[0] = 0; exp_rdata[1] = 0; exp_err[0] = 0; exp_err[1] = 0;
        @(negedge clk);
        do_reset();
        #1;
        check_outputs_zero("reset");
        @(negedge clk);

        txn(1'b0, 1'b1, 12'h010, SZ_W, 32'hDEADBEEF, 32'h0, 1'b0, 1, "p0_store");
        txn(1'b0, 1'b0, 12'h010, SZ_W, 32'h0, 32'hDEADBEEF, 1'b0, 0, "p0_load");

        txn(1'b1, 1'b1, 12'h3FF, SZ_B, 32'h0000_00A5, 32'h0, 1'b0, 1, "edge_store");
        txn(1'b1, 1'b1, 12'h3FE, SZ_W, 32'h1122_3344, 32'h0, 1'b1, 0, "range_store");
        txn(1'b1, 1'b0, 12'h3FF, SZ_BU, 32'h0, 32'h0000_00A5, 1'b0, 0, "edge_load");
        txn(1'b0, 1'b0, 12'h3FF, SZ_B, 32'h0, 32'hFFFF_FFA5, 1'b0, 0, "edge_load_sx");

        // Backpressure: port 1 must wait for the port 0 handshake.
        exp_rdata[0] = 32'hDEADBEEF; exp_err[0] = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 12'h010, SZ_W, 32'h0);
        p0_rready = 1'b0;
        sample(); chk("bp_gnt0", {31'b0, p0_gnt}, 32'h1); next();
        drive(1'b0, 1'b0, 1'b0, 12'h010, SZ_W, 32'h0);
        exp_rdata[1] = 32'h0; exp_err[1] = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 12'h040, SZ_W, 32'h1234_5678);
        p1_rready = 1'b1;
        sample(); chk("bp_access_gnt1", {31'b0, p1_gnt}, 32'h0); next();
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("bp_rvalid0", {31'b0, p0_rvalid}, 32'h1);
            chk("bp_rdata0", p0_rdata, 32'hDEADBEEF);
            chk("bp_hold_gnt1", {31'b0, p1_gnt}, 32'h0);
            next();
        end
        p0_rready = 1'b1;
        sample(); chk("bp_hs_gnt1", {31'b0, p1_gnt}, 32'h0); next();
        sample(); chk("bp_after_gnt1", {31'b0, p1_gnt}, 32'h1);
        chk("bp_after_rvalid0", {31'b0, p0_rvalid}, 32'h0); next();
        drive(1'b1, 1'b0, 1'b1, 12'h040, SZ_W, 32'h1234_5678);
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin sample(); next(); end
        chk("bp_drained", sb.size(), 32'h0);
        txn(1'b0, 1'b0, 12'h040, SZ_W, 32'h0, 32'h1234_5678, 1'b0, 0, "xport_load");

        do_reset();
        run_both(4, 1'b0, "rr");
        for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), glog[i], rr_exp[i]);

        do_reset();
        run_both(7, 1'b1, "lock");
        for (int i = 0; i < 7; i++) chk($sformatf("lock_grant%0d", i), glog[i], lock_exp[i]);

        // Reset during the ACCESS cycle of a byte store.
        txn(1'b0, 1'b1, 12'h020, SZ_B, 32'h0000_0011, 32'h0, 1'b0, 1, "pre_store");
        exp_rdata[0] = 32'h0; exp_err[0] = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 12'h020, SZ_B, 32'h0000_0055);
        sample(); chk("mid_gnt0", {31'b0, p0_gnt}, 32'h1); next();
        drive(1'b0, 1'b0, 1'b1, 12'h020, SZ_B, 32'h0000_0055);
        rst_n = 1'b0;
        #1; chk("mid_mem_we", {31'b0, mem_we}, 32'h0);
        next();
        rst_n = 1'b1;
        sb.delete();
        #1; check_outputs_zero("mid_after");
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sample(); chk("mid_no_rvalid", {31'b0, p0_rvalid | p1_rvalid}, 32'h0); next();
        end
        chk("mid_mem_byte", {24'b0, mem[32]}, 32'h11);
        txn(1'b1, 1'b0, 12'h020, SZ_BU, 32'h0, 32'h0000_0011, 1'b0, 0, "mid_load");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
